// File: rtl/aes_sbox_pipe_if.sv
// rtl/aes_sbox_pipe_if.sv - input/output beat streams of the pipelined AES S-box engine
interface aes_sbox_pipe_if #(
  parameter int LANES = 4,
  parameter int TAG_W = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [8*LANES-1:0]   in_data;
  logic                 in_inv;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [8*LANES-1:0]   out_data;
  logic                 out_inv;
  logic [TAG_W-1:0]     out_tag;

  modport master (
    output in_valid, in_data, in_inv, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_inv, out_tag
  );

  modport slave (
    input  in_valid, in_data, in_inv, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_inv, out_tag
  );
endinterface

// File: rtl/aes_sbox_pipe.sv
// rtl/aes_sbox_pipe.sv - pipelined AES SubBytes/InvSubBytes engine, LANES bytes per beat
// AES_SBOX_PIPE_STATS_EN adds saturating beat/stall counters with a synchronous clear.
module aes_sbox_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef AES_SBOX_PIPE_STATS_EN
  input  logic        stats_clr,
  output logic [31:0] beat_count,
  output logic [31:0] stall_count,
`endif
  aes_sbox_pipe_if.slave bus
);

  localparam int W = 8 * LANES;

  if (LANES < 1 || LANES > 16) begin : g_bad_lanes
    $error("aes_sbox_pipe: LANES must be 1..16");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("aes_sbox_pipe: STAGES must be 1..4");
  end
  if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag
    $error("aes_sbox_pipe: TAG_W must be 1..16");
  end

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the field inverse and maps 0 to 0 without a special case
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = gf_inv(x);
    return y ^ rotl8(y, 1) ^ rotl8(y, 2) ^ rotl8(y, 3) ^ rotl8(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
  endfunction

  logic [W-1:0] w_sub;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_sub[8*i +: 8] = bus.in_inv ? inv_sbox(bus.in_data[8*i +: 8])
                                        : fwd_sbox(bus.in_data[8*i +: 8]);
  end

  logic [STAGES:1] r_v;
  logic [STAGES:1] r_inv;
  logic [W-1:0]     r_data [1:STAGES];
  logic [TAG_W-1:0] r_tag  [1:STAGES];
  logic [STAGES:1]  w_adv;
  logic             w_accept;

  // a slot may load when it is empty or its successor is moving, so bubbles collapse
  always_comb begin
    logic carry;
    w_adv = '0;
    carry = bus.out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      carry    = !r_v[k] | carry;
      w_adv[k] = carry;
    end
  end

  assign bus.in_ready = w_adv[1] & !rst;
  assign w_accept     = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v   <= '0;
      r_inv <= '0;
      for (int k = 1; k <= STAGES; k++) begin
        r_data[k] <= '0;
        r_tag[k]  <= '0;
      end
    end else begin
      if (w_adv[1]) begin
        r_v[1]    <= w_accept;
        r_data[1] <= w_sub;
        r_inv[1]  <= bus.in_inv;
        r_tag[1]  <= bus.in_tag;
      end
      for (int k = 2; k <= STAGES; k++) begin
        if (w_adv[k]) begin
          r_v[k]    <= r_v[k-1];
          r_data[k] <= r_data[k-1];
          r_inv[k]  <= r_inv[k-1];
          r_tag[k]  <= r_tag[k-1];
        end
      end
    end
  end

  assign bus.out_valid = r_v[STAGES];
  assign bus.out_data  = r_data[STAGES];
  assign bus.out_inv   = r_inv[STAGES];
  assign bus.out_tag   = r_tag[STAGES];

`ifdef AES_SBOX_PIPE_STATS_EN
  logic [31:0] r_beat_count;
  logic [31:0] r_stall_count;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      r_beat_count  <= '0;
      r_stall_count <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready && r_beat_count != 32'hFFFF_FFFF)
        r_beat_count <= r_beat_count + 32'd1;
      if (bus.out_valid && !bus.out_ready && r_stall_count != 32'hFFFF_FFFF)
        r_stall_count <= r_stall_count + 32'd1;
    end
  end

  assign beat_count  = r_beat_count;
  assign stall_count = r_stall_count;
`else
  // datapath only: no counters
`endif

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// tb/tb_aes_sbox_pipe.sv - scoreboard bench for aes_sbox_pipe (LANES=4, STAGES=2, TAG_W=4)
// Exercises AES_SBOX_PIPE_STATS_EN counters when that macro is defined.
module tb_aes_sbox_pipe;
  localparam int LANES  = 4;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_sbox_pipe_if #(.LANES(LANES), .TAG_W(TAG_W)) bus ();

`ifdef AES_SBOX_PIPE_STATS_EN
  logic        stats_clr;
  logic [31:0] beat_count;
  logic [31:0] stall_count;
`endif

  aes_sbox_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef AES_SBOX_PIPE_STATS_EN
    .stats_clr(stats_clr),
    .beat_count(beat_count),
    .stall_count(stall_count),
`endif
    .bus(bus)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        inv;
    logic [3:0]  tag;
  } beat_t;

  beat_t sb_q[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    n_acc = 0;
  int    n_out = 0;
  bit    chk_ready = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t held;

  // FIPS-197 forward S-box
  logic [7:0] sbox_tbl [0:255] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  logic [7:0] isbox_tbl [0:255];

  bit ready_pat [0:15] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,
                           1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,1'b1};

  function automatic logic [31:0] fwd_word(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = sbox_tbl[d[8*j +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] inv_word(input logic [31:0] d);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = isbox_tbl[d[8*j +: 8]];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic inv, input logic [3:0] tag,
                      input logic [31:0] exp);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_inv   = inv;
    bus.in_tag   = tag;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout got=in_ready_low want=accept tag=%h", tag);
    end else begin
      sb_q.push_back({exp, inv, tag});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t;
    bus.in_valid = 1'b0;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain_empty", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic wait_out_valid();
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("wait_out_valid", 64'(bus.out_valid), 64'd1);
  endtask

  always @(negedge clk) begin
    beat_t got;
    beat_t exp;
    if (rst) begin
      n_acc      = 0;
      n_out      = 0;
      prev_stall = 1'b0;
    end else begin
      got = {bus.out_data, bus.out_inv, bus.out_tag};
      if (chk_ready)
        check("in_ready_model", 64'(bus.in_ready),
              64'(((n_acc - n_out) < STAGES) || bus.out_ready));
      if (prev_stall)
        check("hold_stable", 64'({bus.out_valid, got}), 64'({1'b1, held}));
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat got=%h want=none", got);
        end else begin
          exp = sb_q.pop_front();
          check("beat", 64'(got), 64'(exp));
        end
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) n_acc++;
      prev_stall = bus.out_valid && !bus.out_ready;
      held       = got;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] d;
    logic [31:0] x;
    for (int i = 0; i < 256; i++) isbox_tbl[sbox_tbl[i]] = 8'(i);
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_inv    = 1'b0;
    bus.in_tag    = '0;
    bus.out_ready = 1'b1;
`ifdef AES_SBOX_PIPE_STATS_EN
    stats_clr = 1'b0;
`endif

    // reset state
    @(negedge clk);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_tag", 64'({bus.out_inv, bus.out_tag}), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;

    // directed vectors and latency
    send(32'h53FF0100, 1'b0, 4'h5, 32'hED167C63);
    bus.in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(STAGES));
    @(posedge clk);
    #1;
    send(32'hED167C63, 1'b1, 4'h6, 32'h53FF0100);
    send(32'hC9F0C9F0, 1'b0, 4'h7, 32'hDD8CDD8C);
    send(32'hDD8C0000, 1'b1, 4'h8, 32'hC9F05252);
    drain();

    // every byte in every lane, forward then inverse of forward
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 4; j++) d[8*j +: 8] = 8'(i + 67 * j);
      send(d, 1'b0, 4'(i), fwd_word(d));
    end
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 4; j++) x[8*j +: 8] = 8'(i + 29 * j);
      send(fwd_word(x), 1'b1, 4'(i), x);
    end
    drain();

    // backpressure with mixed modes
    chk_ready = 1'b1;
    fork
      begin
        for (int t = 0; t < 8; t++) begin
          logic [3:0] tg;
          tg = 4'(t);
          d  = {tg, 4'h3, tg, 4'hC, ~tg, 4'h7, tg, tg};
          send(d, tg[0], tg, tg[0] ? inv_word(d) : fwd_word(d));
        end
        bus.in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 16; c++) begin
          bus.out_ready = ready_pat[c];
          @(posedge clk);
          #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    drain();
    chk_ready = 1'b0;

    // reset with two beats in flight
    bus.out_ready = 1'b0;
    send(32'h00010203, 1'b0, 4'hA, fwd_word(32'h00010203));
    send(32'h04050607, 1'b0, 4'hB, fwd_word(32'h04050607));
    bus.in_valid = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst_out_fields", 64'({bus.out_data, bus.out_inv, bus.out_tag}), 64'd0);
    check("midrst_in_ready_back", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(32'h11223344, 1'b1, 4'hC, inv_word(32'h11223344));
    drain();

`ifdef AES_SBOX_PIPE_STATS_EN
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    check("stats_idle_clr", 64'({beat_count, stall_count}), 64'd0);
    for (int t = 0; t < 4; t++) send(32'(t * 32'h01010101), 1'b0, 4'(t), fwd_word(32'(t * 32'h01010101)));
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(32'hA5A5A5A5, 1'b0, 4'h4, fwd_word(32'hA5A5A5A5));
    bus.in_valid = 1'b0;
    wait_out_valid();
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("beat_count", 64'(beat_count), 64'd5);
    check("stall_count", 64'(stall_count), 64'd3);
    send(32'h5A5A5A5A, 1'b1, 4'h9, inv_word(32'h5A5A5A5A));
    bus.in_valid = 1'b0;
    wait_out_valid();
    stats_clr = 1'b1;
    @(posedge clk);
    #1;
    stats_clr = 1'b0;
    check("stats_clr_handshake", 64'({beat_count, stall_count}), 64'd0);
    drain();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
